// File: rtl/esp_dma_responder_if.sv
// ESP accelerator DMA bundle: read/write ctrl requests plus read/write data channels.
// The accelerator drives it as master; the memory responder sits on the slave modport.
interface esp_dma_responder_if #(
  parameter int DATA_W = 64
);
  logic              dma_read_ctrl_valid;
  logic              dma_read_ctrl_ready;
  logic [31:0]       dma_read_ctrl_data_index;
  logic [31:0]       dma_read_ctrl_data_length;
  logic [2:0]        dma_read_ctrl_data_size;
  logic [5:0]        dma_read_ctrl_data_user;
  logic              dma_read_chnl_valid;
  logic              dma_read_chnl_ready;
  logic [DATA_W-1:0] dma_read_chnl_data;
  logic              dma_write_ctrl_valid;
  logic              dma_write_ctrl_ready;
  logic [31:0]       dma_write_ctrl_data_index;
  logic [31:0]       dma_write_ctrl_data_length;
  logic [2:0]        dma_write_ctrl_data_size;
  logic [5:0]        dma_write_ctrl_data_user;
  logic              dma_write_chnl_valid;
  logic              dma_write_chnl_ready;
  logic [DATA_W-1:0] dma_write_chnl_data;

  modport master (
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_ctrl_data_user,
           dma_write_chnl_valid, dma_write_chnl_data,
    input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );

  modport slave (
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_ctrl_data_user,
           dma_write_chnl_valid, dma_write_chnl_data,
    output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );
endinterface

// File: rtl/esp_dma_responder.sv
// DMA responder serving ESP read/write bursts from an internal word-addressed
// memory, with a backdoor port for preload and inspection while idle.
module esp_dma_responder #(
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = 65536,
  parameter int RD_LAT    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  esp_dma_responder_if.slave           dma,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
  input  logic [DATA_W-1:0]            bd_wdata,
  output logic [DATA_W-1:0]            bd_rdata,
  output logic                         busy,
  output logic                         err_oob,
  output logic                         err_size,
  output logic [31:0]                  rd_beats,
  output logic [31:0]                  wr_beats
);
  localparam int         AW      = $clog2(MEM_WORDS);
  localparam logic [2:0] SIZE_DW = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_BURST = 2'd2,
    ST_WR_BURST = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ctrl_rdy;
  logic [31:0]       r_index;
  logic [31:0]       r_len;
  logic [31:0]       r_k;
  logic [31:0]       r_lat_cnt;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_wr_ready;
  logic              r_err_oob;
  logic              r_err_size;
  logic [31:0]       r_rd_beats;
  logic [31:0]       r_wr_beats;
  logic [DATA_W-1:0] r_bd_rdata;
  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_rd_hs;
  logic              w_wr_hs;
  logic              w_rd_load;
  logic              w_rd_fetch;
  logic              w_last;
  logic [31:0]       w_rd_k;
  logic [AW-1:0]     w_rd_addr;
  logic [AW-1:0]     w_wr_addr;
  logic              w_unused_ok;

  function automatic logic [AW-1:0] f_addr(input logic [31:0] base, input logic [31:0] k);
    logic [32:0] sum;
    sum = {1'b0, base} + {1'b0, k};
    return sum[AW-1:0];
  endfunction

  function automatic logic f_oob(input logic [31:0] base, input logic [31:0] k);
    logic [32:0] sum;
    sum = {1'b0, base} + {1'b0, k};
    return (sum >= 33'(MEM_WORDS));
  endfunction

  // A read request always wins over a simultaneous write request.
  assign w_rd_acc   = (r_state == ST_IDLE) && r_ctrl_rdy && dma.dma_read_ctrl_valid;
  assign w_wr_acc   = (r_state == ST_IDLE) && r_ctrl_rdy && !dma.dma_read_ctrl_valid
                      && dma.dma_write_ctrl_valid;
  assign w_rd_hs    = (r_state == ST_RD_BURST) && r_rd_valid && dma.dma_read_chnl_ready;
  assign w_wr_hs    = (r_state == ST_WR_BURST) && r_wr_ready && dma.dma_write_chnl_valid;
  assign w_rd_load  = (r_state == ST_RD_BURST) && !r_rd_valid && (r_k < r_len);
  assign w_last     = (r_k == (r_len - 32'd1));
  assign w_rd_fetch = w_rd_load || (w_rd_hs && !w_last);
  assign w_rd_k     = r_rd_valid ? (r_k + 32'd1) : r_k;
  assign w_rd_addr  = f_addr(r_index, w_rd_k);
  assign w_wr_addr  = f_addr(r_index, r_k);

  assign w_unused_ok = ^{dma.dma_read_ctrl_data_user, dma.dma_write_ctrl_data_user};

  assign dma.dma_read_ctrl_ready  = (r_state == ST_IDLE) && r_ctrl_rdy;
  assign dma.dma_write_ctrl_ready = (r_state == ST_IDLE) && r_ctrl_rdy && !dma.dma_read_ctrl_valid;
  assign dma.dma_read_chnl_valid  = r_rd_valid;
  assign dma.dma_read_chnl_data   = r_rd_data;
  assign dma.dma_write_chnl_ready = r_wr_ready;
  assign busy     = (r_state != ST_IDLE);
  assign err_oob  = r_err_oob;
  assign err_size = r_err_size;
  assign rd_beats = r_rd_beats;
  assign wr_beats = r_wr_beats;
  assign bd_rdata = r_bd_rdata;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode; zero-length requests spend exactly one cycle out of IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_acc) begin
          if ((dma.dma_read_ctrl_data_length == 32'd0) || (RD_LAT == 0)) begin
            w_state_nxt = ST_RD_BURST;
          end else begin
            w_state_nxt = ST_RD_WAIT;
          end
        end else if (w_wr_acc) begin
          w_state_nxt = ST_WR_BURST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (r_lat_cnt <= 32'd1) begin
          w_state_nxt = ST_RD_BURST;
        end else begin
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_BURST: begin
        if (!r_rd_valid && (r_k >= r_len)) begin
          w_state_nxt = ST_IDLE;
        end else if (w_rd_hs && w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RD_BURST;
        end
      end
      ST_WR_BURST: begin
        if (r_len == 32'd0) begin
          w_state_nxt = ST_IDLE;
        end else if (w_wr_hs && w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WR_BURST;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request latching, beat sequencing, channel outputs, error flags and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl_rdy  <= 1'b0;
      r_index     <= 32'd0;
      r_len       <= 32'd0;
      r_k         <= 32'd0;
      r_lat_cnt   <= 32'd0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_wr_ready  <= 1'b0;
      r_err_oob   <= 1'b0;
      r_err_size  <= 1'b0;
      r_rd_beats  <= 32'd0;
      r_wr_beats  <= 32'd0;
    end else begin
      r_ctrl_rdy <= (w_state_nxt == ST_IDLE);
      if (w_rd_acc) begin
        r_index   <= dma.dma_read_ctrl_data_index;
        r_len     <= dma.dma_read_ctrl_data_length;
        r_k       <= 32'd0;
        r_lat_cnt <= 32'(RD_LAT);
        if (dma.dma_read_ctrl_data_size != SIZE_DW) begin
          r_err_size <= 1'b1;
        end
      end else if (w_wr_acc) begin
        r_index    <= dma.dma_write_ctrl_data_index;
        r_len      <= dma.dma_write_ctrl_data_length;
        r_k        <= 32'd0;
        r_wr_ready <= (dma.dma_write_ctrl_data_length != 32'd0);
        if (dma.dma_write_ctrl_data_size != SIZE_DW) begin
          r_err_size <= 1'b1;
        end
      end
      if (r_state == ST_RD_WAIT) begin
        r_lat_cnt <= r_lat_cnt - 32'd1;
      end
      if (w_rd_hs) begin
        r_k        <= r_k + 32'd1;
        r_rd_beats <= r_rd_beats + 32'd1;
        if (w_last) begin
          r_rd_valid <= 1'b0;
        end
      end
      // The next beat is fetched on the handshake edge so a held-ready stream has no bubbles.
      if (w_rd_fetch) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= r_mem[w_rd_addr];
        if (f_oob(r_index, w_rd_k)) begin
          r_err_oob <= 1'b1;
        end
      end
      if (w_wr_hs) begin
        r_k        <= r_k + 32'd1;
        r_wr_beats <= r_wr_beats + 32'd1;
        if (w_last) begin
          r_wr_ready <= 1'b0;
        end
        if (f_oob(r_index, r_k)) begin
          r_err_oob <= 1'b1;
        end
      end
    end
  end

  // Memory array and backdoor read port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_hs) begin
      r_mem[w_wr_addr] <= dma.dma_write_chnl_data;
    end else if ((r_state == ST_IDLE) && bd_we) begin
      r_mem[bd_addr] <= bd_wdata;
    end
    r_bd_rdata <= r_mem[bd_addr];
  end
endmodule

// File: tb/tb_esp_dma_responder.sv
// Randomized scoreboard bench for esp_dma_responder (256-word memory, RD_LAT = 2):
// expected beats come from a reference memory image and are checked by a separate monitor.
module tb_esp_dma_responder;
  localparam int DW  = 64;
  localparam int MW  = 256;
  localparam int LAT = 2;

  logic          clk;
  logic          rst_n;
  logic          bd_we;
  logic [7:0]    bd_addr;
  logic [DW-1:0] bd_wdata;
  logic [DW-1:0] bd_rdata;
  logic          busy;
  logic          err_oob;
  logic          err_size;
  logic [31:0]   rd_beats;
  logic [31:0]   wr_beats;

  esp_dma_responder_if #(.DATA_W(DW)) dma ();

  esp_dma_responder #(.DATA_W(DW), .MEM_WORDS(MW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .dma(dma.slave),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata),
    .busy(busy), .err_oob(err_oob), .err_size(err_size),
    .rd_beats(rd_beats), .wr_beats(wr_beats)
  );

  int            n_chk = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic [DW-1:0] ref_mem [MW];
  logic [DW-1:0] sb_q [$];
  bit            first_pend = 0;
  int            acc_cyc = 0;
  int            first_lat = -1;
  bit            hs_first_seen = 0;
  int            hs_first_cyc = 0;
  int            hs_last_cyc = 0;
  bit            chk_drop = 0;
  bit            held_v = 0;
  logic [DW-1:0] held_d = '0;
  bit            rdy_rand = 0;
  int            exp_rd = 0;
  int            exp_wr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read-channel ready generator: constant high or random backpressure.
  always @(posedge clk) begin
    #1;
    dma.dma_read_chnl_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every read handshake and checks hold/drop behaviour.
  always @(negedge clk) begin
    if (chk_drop) begin
      chk("rd_valid_drop", dma.dma_read_chnl_valid, 1'b0);
      chk_drop = 0;
    end
    if (held_v) begin
      chk("rd_hold_valid", dma.dma_read_chnl_valid, 1'b1);
      chk("rd_hold_data", dma.dma_read_chnl_data, held_d);
      held_v = 0;
    end
    if (dma.dma_read_chnl_valid) begin
      if (first_pend) begin
        first_lat  = cyc - acc_cyc;
        first_pend = 0;
      end
      if (sb_q.size() == 0) begin
        chk("rd_unexpected_beat", 1'b1, 1'b0);
      end else if (dma.dma_read_chnl_ready) begin
        chk("rd_data", dma.dma_read_chnl_data, sb_q.pop_front());
        if (!hs_first_seen) begin
          hs_first_cyc  = cyc + 1;
          hs_first_seen = 1;
        end
        hs_last_cyc = cyc + 1;
        if (sb_q.size() == 0) chk_drop = 1;
      end else begin
        held_v = 1;
        held_d = dma.dma_read_chnl_data;
      end
    end
  end

  task automatic wait_ctrl(input bit is_wr);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (is_wr ? dma.dma_write_ctrl_ready : dma.dma_read_ctrl_ready) begin
        ok = 1;
        break;
      end
    end
    chk(is_wr ? "wr_ctrl_accept" : "rd_ctrl_accept", 64'(ok), 64'd1);
  endtask

  task automatic bd_write(input int a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = 8'(a); bd_wdata = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic bd_check(input string name, input int a);
    @(posedge clk); #1;
    bd_addr = 8'(a);
    @(posedge clk);
    @(negedge clk);
    chk(name, bd_rdata, ref_mem[a]);
  endtask

  task automatic do_read(input int idx, input int len, input logic [2:0] size);
    bit done = 0;
    for (int k = 0; k < len; k++) sb_q.push_back(ref_mem[(idx + k) % MW]);
    first_lat     = -1;
    first_pend    = (len > 0);
    hs_first_seen = 0;
    @(posedge clk); #1;
    dma.dma_read_ctrl_valid       = 1'b1;
    dma.dma_read_ctrl_data_index  = 32'(idx);
    dma.dma_read_ctrl_data_length = 32'(len);
    dma.dma_read_ctrl_data_size   = size;
    wait_ctrl(1'b0);
    @(posedge clk); #1;
    acc_cyc = cyc;
    dma.dma_read_ctrl_valid = 1'b0;
    exp_rd += len;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    chk("rd_done", 64'(done), 64'd1);
    if (len > 0) chk("rd_latency", 64'(first_lat), 64'(LAT + 1));
    if (len > 0 && !rdy_rand) chk("rd_throughput", 64'(hs_last_cyc - hs_first_cyc), 64'(len - 1));
    chk("rd_beats", rd_beats, 64'(exp_rd));
  endtask

  task automatic wr_beats_drive(input int idx, input int len, input logic [DW-1:0] base,
                                input bit gaps, input int abort_at, output bit aborted);
    aborted = 0;
    for (int k = 0; k < len; k++) begin
      bit ok = 0;
      if (gaps) begin
        dma.dma_write_chnl_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      dma.dma_write_chnl_valid = 1'b1;
      dma.dma_write_chnl_data  = base + DW'(k);
      if (k == abort_at) begin
        rst_n = 1'b0;
        aborted = 1;
        return;
      end
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (dma.dma_write_chnl_ready) begin
          ok = 1;
          break;
        end
      end
      chk("wr_beat_ready", 64'(ok), 64'd1);
      @(posedge clk);
      ref_mem[(idx + k) % MW] = base + DW'(k);
      exp_wr++;
      #1;
    end
    dma.dma_write_chnl_valid = 1'b0;
    @(negedge clk);
    chk("wr_ready_drop", dma.dma_write_chnl_ready, 1'b0);
    chk("wr_beats", wr_beats, 64'(exp_wr));
  endtask

  task automatic do_write(input int idx, input int len, input logic [DW-1:0] base,
                          input bit gaps, input int abort_at);
    bit aborted;
    @(posedge clk); #1;
    dma.dma_write_ctrl_valid       = 1'b1;
    dma.dma_write_ctrl_data_index  = 32'(idx);
    dma.dma_write_ctrl_data_length = 32'(len);
    dma.dma_write_ctrl_data_size   = 3'b011;
    wait_ctrl(1'b1);
    @(posedge clk); #1;
    dma.dma_write_ctrl_valid = 1'b0;
    wr_beats_drive(idx, len, base, gaps, abort_at, aborted);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rd_valid", dma.dma_read_chnl_valid, 1'b0);
    chk("rst_rd_data", dma.dma_read_chnl_data, 64'd0);
    chk("rst_wr_ready", dma.dma_write_chnl_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_oob", err_oob, 1'b0);
    chk("rst_err_size", err_size, 1'b0);
    chk("rst_rd_beats", rd_beats, 64'd0);
    chk("rst_wr_beats", wr_beats, 64'd0);
  endtask

  initial begin
    bit bad_wr;
    bit ok;
    int wr_acc_cyc;
    rst_n = 1'b0;
    bd_we = 1'b0; bd_addr = 8'd0; bd_wdata = '0;
    dma.dma_read_ctrl_valid = 1'b0;  dma.dma_read_ctrl_data_index = 32'd0;
    dma.dma_read_ctrl_data_length = 32'd0; dma.dma_read_ctrl_data_size = 3'b011;
    dma.dma_read_ctrl_data_user = 6'd0;
    dma.dma_write_ctrl_valid = 1'b0; dma.dma_write_ctrl_data_index = 32'd0;
    dma.dma_write_ctrl_data_length = 32'd0; dma.dma_write_ctrl_data_size = 3'b011;
    dma.dma_write_ctrl_data_user = 6'd0;
    dma.dma_write_chnl_valid = 1'b0; dma.dma_write_chnl_data = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rd_ctrl_ready", dma.dma_read_ctrl_ready, 1'b1);
    chk("rst_wr_ctrl_ready", dma.dma_write_ctrl_ready, 1'b1);

    // Preload and a plain read with ready held high.
    for (int i = 0; i < MW; i++) bd_write(i, DW'(i) * 64'h0101);
    do_read(4, 8, 3'b011);

    // Write with valid gaps, read back, check the neighbours by backdoor.
    do_write(100, 4, 64'hA, 1'b1, -1);
    do_read(100, 4, 3'b011);
    bd_check("bd_mem99", 99);
    bd_check("bd_mem104", 104);
    bd_check("bd_mem101", 101);

    // Random backpressure; a backdoor write attempted mid-burst must be dropped.
    rdy_rand = 1;
    fork
      do_read(40, 16, 3'b011);
      begin
        repeat (6) @(posedge clk);
        #1;
        bd_we = 1'b1; bd_addr = 8'd200; bd_wdata = 64'hDEAD_BEEF;
        @(posedge clk); #1;
        bd_we = 1'b0;
      end
    join
    rdy_rand = 0;
    bd_check("bd_dropped_while_busy", 200);

    // Simultaneous read and write requests.
    for (int k = 0; k < 4; k++) sb_q.push_back(ref_mem[10 + k]);
    first_lat = -1; first_pend = 1; hs_first_seen = 0;
    @(posedge clk); #1;
    dma.dma_read_ctrl_valid = 1'b1;  dma.dma_read_ctrl_data_index = 32'd10;
    dma.dma_read_ctrl_data_length = 32'd4; dma.dma_read_ctrl_data_size = 3'b011;
    dma.dma_write_ctrl_valid = 1'b1; dma.dma_write_ctrl_data_index = 32'd20;
    dma.dma_write_ctrl_data_length = 32'd2; dma.dma_write_ctrl_data_size = 3'b011;
    dma.dma_write_chnl_valid = 1'b1; dma.dma_write_chnl_data = 64'h70;
    @(negedge clk);
    chk("sim_rd_ctrl_ready", dma.dma_read_ctrl_ready, 1'b1);
    chk("sim_wr_ctrl_ready", dma.dma_write_ctrl_ready, 1'b0);
    @(posedge clk); #1;
    acc_cyc = cyc;
    dma.dma_read_ctrl_valid = 1'b0;
    exp_rd += 4;
    bad_wr = 0; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dma.dma_write_chnl_ready) bad_wr = 1;
      if (dma.dma_write_ctrl_ready) begin
        ok = 1;
        break;
      end
    end
    chk("sim_wr_ctrl_accept", 64'(ok), 64'd1);
    chk("sim_no_wr_beat_during_rd", 64'(bad_wr), 64'd0);
    chk("sim_rd_done_first", 64'(sb_q.size()), 64'd0);
    chk("sim_rd_latency", 64'(first_lat), 64'(LAT + 1));
    @(posedge clk); #1;
    wr_acc_cyc = cyc;
    dma.dma_write_ctrl_valid = 1'b0;
    chk("sim_wr_accept_edge", 64'(wr_acc_cyc), 64'(hs_last_cyc + 1));
    wr_beats_drive(20, 2, 64'h70, 1'b0, -1, ok);
    do_read(19, 4, 3'b011);

    // Random mixed traffic inside the memory bounds.
    for (int it = 0; it < 8; it++) begin
      int len;
      int idx;
      rdy_rand = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        len = $urandom_range(1, 8);
        idx = $urandom_range(0, MW - len);
        do_write(idx, len, {$urandom, $urandom}, 1'b1, -1);
      end else begin
        len = $urandom_range(1, 16);
        idx = $urandom_range(0, MW - len);
        do_read(idx, len, 3'b011);
      end
    end
    rdy_rand = 0;
    repeat (2) @(posedge clk);

    // Zero-length read: one busy cycle, no beats.
    @(posedge clk); #1;
    dma.dma_read_ctrl_valid = 1'b1; dma.dma_read_ctrl_data_index = 32'd5;
    dma.dma_read_ctrl_data_length = 32'd0; dma.dma_read_ctrl_data_size = 3'b011;
    wait_ctrl(1'b0);
    @(posedge clk); #1;
    dma.dma_read_ctrl_valid = 1'b0;
    @(negedge clk);
    chk("len0_busy", busy, 1'b1);
    @(negedge clk);
    chk("len0_idle", busy, 1'b0);
    chk("len0_ctrl_ready", dma.dma_read_ctrl_ready, 1'b1);
    chk("len0_rd_beats", rd_beats, 64'(exp_rd));

    // Wrap-around read and size error.
    chk("oob_before", err_oob, 1'b0);
    do_read(254, 4, 3'b011);
    chk("oob_after", err_oob, 1'b1);
    chk("size_before", err_size, 1'b0);
    do_read(0, 2, 3'b010);
    chk("size_after", err_size, 1'b1);

    // Reset during a 50-beat write at beat 10.
    do_write(150, 50, 64'h5000, 1'b0, 10);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;
    dma.dma_write_chnl_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rel_rd_ctrl_ready", dma.dma_read_ctrl_ready, 1'b1);
    bd_check("rst_mem150", 150);
    bd_check("rst_mem159", 159);
    bd_check("rst_mem160", 160);
    do_read(148, 14, 3'b011);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/esp_dma_responder.md
# esp_dma_responder

Synthesizable DMA responder that serves the ESP accelerator DMA interface (read ctrl/chnl, write ctrl/chnl) from an internal word-addressed memory. It is the slave end of the interface that `rtl_trees` drives as initiator. It replaces the behavioural memory agent in benches and FPGA smoke tests, so that tree images, feature images and prediction write-backs can be exercised without an ESP socket. A backdoor port preloads and inspects memory while the responder is idle.

## Interface
- `DATA_W`, 64: DMA beat width; index and length are counted in `DATA_W` words.
- `MEM_WORDS`, 65536: memory depth in words. Must be a power of two.
- `RD_LAT`, 2: idle cycles between read-ctrl accept and the first read beat becoming eligible for valid.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `dma_read_ctrl_valid`/`dma_read_ctrl_ready` in/out 1: read request handshake.
- `dma_read_ctrl_data_index` in 32: start word.
- `dma_read_ctrl_data_length` in 32: beats to return.
- `dma_read_ctrl_data_size` in 3: beat size; 3'b011 is legal.
- `dma_read_ctrl_data_user` in 6: ignored.
- `dma_read_chnl_valid` out 1, `dma_read_chnl_ready` in 1, `dma_read_chnl_data` out `DATA_W`: read data stream.
- `dma_write_ctrl_valid`/`dma_write_ctrl_ready` in/out 1: write request handshake.
- `dma_write_ctrl_data_index`, `dma_write_ctrl_data_length`, `dma_write_ctrl_data_size`, `dma_write_ctrl_data_user` in 32/32/3/6: same meaning as the read side.
- `dma_write_chnl_valid` in 1, `dma_write_chnl_ready` out 1, `dma_write_chnl_data` in `DATA_W`: write data stream.
- `bd_we` in 1, `bd_addr` in log2(`MEM_WORDS`), `bd_wdata` in `DATA_W`, `bd_rdata` out `DATA_W`: backdoor access.
- `busy` out 1: the FSM is not in IDLE.
- `err_oob` out 1: sticky; a burst touched an address ≥ `MEM_WORDS`.
- `err_size` out 1: sticky; a ctrl request arrived with size ≠ 3'b011.
- `rd_beats`, `wr_beats` out 32: cumulative completed beats.

## Operation
- FSM states:
  - IDLE: `dma_read_ctrl_ready` = `dma_write_ctrl_ready` = 1.
  - RD_WAIT: counts down `RD_LAT`.
  - RD_BURST.
  - WR_BURST.
- IDLE transitions:
  - Read accept → RD_WAIT, or directly RD_BURST if `RD_LAT` = 0.
  - Write accept → WR_BURST.
  - Both ctrl valid in the same cycle: read wins. In that cycle only `dma_read_ctrl_ready` is high, and the write ctrl stays pending.
- On accept, index, length and a beat counter k=0 are latched.
- Word address = (index + k) mod `MEM_WORDS`. If index + k ≥ `MEM_WORDS`, `err_oob` is set and the access still proceeds at the wrapped address.
- A size other than 3'b011 sets `err_size`. The request is still served as `DATA_W` beats.
- RD_BURST:
  - Beat k carries `mem[addr(k)]`.
  - valid stays high and data stays stable until ready.
  - Each handshake increments k and `rd_beats`.
  - After beat length-1 is handed off → IDLE.
- WR_BURST:
  - `dma_write_chnl_ready` = 1.
  - Each handshake writes `dma_write_chnl_data` to `mem[addr(k)]` and increments k and `wr_beats`.
  - After beat length-1 → IDLE.
- Length 0: the request is accepted, no beats are transferred, and the FSM returns to IDLE on the next cycle.
- Backdoor:
  - `bd_we` is honoured only in IDLE and is dropped otherwise.
  - `bd_rdata` = `mem[bd_addr]`, one cycle after `bd_addr` is sampled, in any state.
- Memory contents are not reset.

## Timing
- Reset values:
  - state IDLE.
  - All valid outputs 0.
  - `dma_read_chnl_data` 0.
  - `busy`, `err_oob`, `err_size` 0.
  - Beat counters 0.
  - Ctrl readies become 1 in the first cycle after reset release.
- Reset mid-burst aborts immediately. No further beats are produced, and writes already committed remain in memory.
- Read latency: accept at edge T → first valid at edge T+1+`RD_LAT`.
- Read throughput: one beat per cycle while ready is held high. No bubbles between beats, including the transition out of RD_WAIT.
- Deassertion:
  - `dma_read_chnl_valid` drops in the cycle after the last handshake.
  - `dma_write_chnl_ready` drops in the cycle after the last write handshake.
- Readback: a DMA write at edge T is visible on a read burst or backdoor access sampled at T+1 or later.
- Ctrl readies are 0 in every non-IDLE state.
- The first cycle a new request can be accepted is the cycle after the FSM returns to IDLE.

## Test plan
- **Backdoor preload and read:** preload `mem[i]` = i·0x0101 for i < 32, then read index 4, length 8, `RD_LAT` = 2, ready constant high → beats 0x0404…0x0B0B on 8 consecutive cycles, first valid 3 cycles after accept, `rd_beats` = 8.
- **Write, then read back:** write index 100, length 4, data 0xA..0xD with valid gaps inserted, then read index 100, length 4 → 0xA..0xD. Backdoor `mem[99]` and `mem[104]` unchanged; `wr_beats` = 4.
- **Backpressure:** read length 16 with random `dma_read_chnl_ready` → each beat's data is held until its handshake, no beats are lost or duplicated, and the last valid drops 1 cycle after the final handshake.
- **Simultaneous requests:** read and write ctrl valid in the same cycle → the read is accepted first, the write is accepted in the first IDLE cycle after the read completes, and no write beat is taken during the read.
- **Wrap and size error:** `MEM_WORDS` = 256, read index 254, length 4 → `mem[254]`, `mem[255]`, `mem[0]`, `mem[1]` returned and `err_oob` = 1. A later request with size 3'b010 → `err_size` = 1.
- **Length 0 and reset:** a length-0 read returns to IDLE in 1 cycle with no valid. `rst_n` pulled low during a 50-beat write at beat 10 → all outputs return to reset values, only beats 0..9 are written, and a new read is accepted after release.
